// File: rtl/stream_packet_fifo.sv
// Packet-aware FIFO behind the QoS stream arbiter: stores {data,qos,id,last} beats and counts complete packets.
// Define STREAM_PACKET_FIFO_STORE_FWD_EN to hold output until a whole packet is buffered.
module stream_packet_fifo #(
  parameter int T_DATA_WIDTH = 8,
  parameter int T_QOS__WIDTH = 4,
  parameter int STREAM_COUNT = 2,
  parameter int T_ID___WIDTH = $clog2(STREAM_COUNT),
  parameter int FIFO_DEPTH   = 8,
  parameter int CNT_WIDTH    = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [T_DATA_WIDTH-1:0] s_data_i,
  input  logic [T_QOS__WIDTH-1:0] s_qos_i,
  input  logic [T_ID___WIDTH-1:0] s_id_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic [T_QOS__WIDTH-1:0] m_qos_o,
  output logic [T_ID___WIDTH-1:0] m_id_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic [CNT_WIDTH-1:0]    count_o,
  output logic [CNT_WIDTH-1:0]    pkt_count_o
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(FIFO_DEPTH);

  typedef struct packed {
    logic [T_DATA_WIDTH-1:0] data;
    logic [T_QOS__WIDTH-1:0] qos;
    logic [T_ID___WIDTH-1:0] id;
    logic                    last;
  } beat_t;

  beat_t                mem [FIFO_DEPTH];
  beat_t                s_beat, head, out_beat;
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_WIDTH-1:0] count, pkt_count;
  logic                 full, empty, wr_en, rd_en, valid;

  assign s_beat = '{data: s_data_i, qos: s_qos_i, id: s_id_i, last: s_last_i};
  assign head   = mem[rd_ptr];
  assign full   = (count == DEPTH_C);
  assign empty  = (count == '0);

`ifdef STREAM_PACKET_FIFO_STORE_FWD_EN
  // Full with no complete packet degrades to cut-through so oversize packets cannot deadlock.
  assign valid = ~empty & ((pkt_count != '0) | full);
`else
  assign valid = ~empty;
`endif

  assign s_ready_o = ~rst_i & ~full;
  assign m_valid_o = ~rst_i & valid;
  assign wr_en     = s_valid_i & s_ready_o;
  assign rd_en     = m_valid_o & m_ready_i;

  assign out_beat    = rst_i ? '0 : head;
  assign m_data_o    = out_beat.data;
  assign m_qos_o     = out_beat.qos;
  assign m_id_o      = out_beat.id;
  assign m_last_o    = out_beat.last;
  assign count_o     = count;
  assign pkt_count_o = pkt_count;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pkt_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= s_beat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      case ({wr_en & s_last_i, rd_en & head.last})
        2'b10:   pkt_count <= pkt_count + 1'b1;
        2'b01:   pkt_count <= pkt_count - 1'b1;
        default: pkt_count <= pkt_count;
      endcase
    end
  end
endmodule

// File: tb/tb_stream_packet_fifo.sv
// Scoreboarded directed test for stream_packet_fifo; expected beats queued on acceptance, checked by a negedge monitor.
module tb_stream_packet_fifo;
  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [7:0] s_data_i = '0;
  logic [3:0] s_qos_i = '0;
  logic [0:0] s_id_i = '0;
  logic       s_last_i = 1'b0;
  logic       s_valid_i = 1'b0;
  logic       s_ready_o;
  logic [7:0] m_data_o;
  logic [3:0] m_qos_o;
  logic [0:0] m_id_o;
  logic       m_last_o;
  logic       m_valid_o;
  logic       m_ready_i = 1'b0;
  logic [3:0] count_o;
  logic [3:0] pkt_count_o;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] qos;
    logic [0:0] id;
    logic       last;
  } beat_t;

  beat_t sb[$];
  int n_chk = 0;
  int n_fail = 0;
  bit sf_mode;

  stream_packet_fifo dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_data_i(s_data_i), .s_qos_i(s_qos_i), .s_id_i(s_id_i), .s_last_i(s_last_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .m_data_o(m_data_o), .m_qos_o(m_qos_o), .m_id_o(m_id_o), .m_last_o(m_last_o),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .count_o(count_o), .pkt_count_o(pkt_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every handshake at the coming edge must match the oldest expected beat.
  always @(negedge clk_i) begin
    if (!rst_i && m_valid_o && m_ready_i) begin
      if (sb.size() == 0) begin
        chk("unexpected_pop", {m_data_o, m_qos_o, m_id_o, m_last_o}, 32'hFFFF_FFFF);
      end else begin
        beat_t e;
        e = sb.pop_front();
        chk("out_data", m_data_o, e.data);
        chk("out_qos",  m_qos_o,  e.qos);
        chk("out_id",   m_id_o,   e.id);
        chk("out_last", m_last_o, e.last);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk_i); #1;
  endtask

  // Offers one beat for one cycle; starts and ends at posedge+1.
  task automatic put(input logic [7:0] d, input logic [3:0] q, input logic id,
                     input logic last, output bit acc);
    beat_t b;
    b = '{data: d, qos: q, id: id, last: last};
    s_valid_i = 1'b1; s_data_i = d; s_qos_i = q; s_id_i = id; s_last_i = last;
    @(negedge clk_i);
    acc = s_ready_o;
    if (acc) sb.push_back(b);
    next_cycle();
    s_valid_i = 1'b0; s_last_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    m_ready_i = 1'b1;
    @(negedge clk_i);
    while (count_o != 0 && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    chk("drain_count", count_o, 0);
    chk("drain_sb", sb.size(), 0);
    next_cycle();
    m_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("rst_s_ready", s_ready_o, 0);
    chk("rst_m_valid", m_valid_o, 0);
    chk("rst_m_fields", {m_data_o, m_qos_o, m_id_o, m_last_o}, 0);
    next_cycle();
    rst_i = 1'b0;
    sb.delete();
    @(negedge clk_i);
    chk("post_rst_count", count_o, 0);
    chk("post_rst_pkt", pkt_count_o, 0);
    chk("post_rst_m_valid", m_valid_o, 0);
    chk("post_rst_s_ready", s_ready_o, 1);
    next_cycle();
  endtask

  initial begin
    bit acc;
`ifdef STREAM_PACKET_FIFO_STORE_FWD_EN
    sf_mode = 1'b1;
`else
    sf_mode = 1'b0;
`endif
    next_cycle();
    do_reset();

    // Three-beat packet, consumer always ready; first-word fall-through latency.
    m_ready_i = 1'b1;
    put(8'h11, 4'h1, 1'b0, 1'b0, acc);
    chk("t1_acc", acc, 1);
    @(negedge clk_i);
    chk("t1_latency_valid", m_valid_o, !sf_mode);
    if (!sf_mode) chk("t1_latency_data", m_data_o, 8'h11);
    next_cycle();
    put(8'h22, 4'h2, 1'b0, 1'b0, acc);
    put(8'h33, 4'h3, 1'b0, 1'b1, acc);
    drain();

    // Fill to full with consumer stalled; 9th beat refused; one pop reopens input.
    m_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) put(8'h80 + 8'(i), 4'(i), 1'(i), (i == 3 || i == 7), acc);
    @(negedge clk_i);
    chk("t2_full_count", count_o, 8);
    chk("t2_full_pkt", pkt_count_o, 2);
    chk("t2_full_ready", s_ready_o, 0);
    next_cycle();
    put(8'h99, 4'h9, 1'b1, 1'b1, acc);
    chk("t2_9th_refused", acc, 0);
    m_ready_i = 1'b1;
    @(negedge clk_i);
    chk("t2_ready_while_pop", s_ready_o, 0);
    next_cycle();
    m_ready_i = 1'b0;
    @(negedge clk_i);
    chk("t2_ready_after_pop", s_ready_o, 1);
    chk("t2_count_after_pop", count_o, 7);
    next_cycle();
    drain();

    // Steady state at count 4: 20 cycles of simultaneous write+read, pointers wrap.
    for (int i = 0; i < 3; i++) put(8'h40 + 8'(i), 4'h4, 1'b0, 1'b0, acc);
    put(8'h43, 4'h4, 1'b1, 1'b1, acc);
    for (int i = 0; i < 20; i++) begin
      s_valid_i = 1'b1; s_data_i = 8'hA0 + 8'(i); s_qos_i = 4'(i);
      s_id_i = 1'(i); s_last_i = (i % 4 == 3);
      m_ready_i = 1'b1;
      @(negedge clk_i);
      if (i % 5 == 0) chk("t3_count_steady", count_o, 4);
      if (s_ready_o) sb.push_back('{data: s_data_i, qos: s_qos_i, id: s_id_i, last: s_last_i});
      next_cycle();
    end
    s_valid_i = 1'b0; s_last_i = 1'b0;
    m_ready_i = 1'b0;
    @(negedge clk_i);
    chk("t3_count_end", count_o, 4);
    chk("t3_pkt_end", pkt_count_o, 1);
    next_cycle();
    drain();

    // Sideband fields and packet count on a single-beat packet.
    put(8'h5C, 4'hA, 1'b1, 1'b1, acc);
    @(negedge clk_i);
    chk("t4_qos", m_qos_o, 4'hA);
    chk("t4_id", m_id_o, 1);
    chk("t4_last", m_last_o, 1);
    chk("t4_data", m_data_o, 8'h5C);
    chk("t4_pkt_before", pkt_count_o, 1);
    next_cycle();
    m_ready_i = 1'b1;
    next_cycle();
    m_ready_i = 1'b0;
    @(negedge clk_i);
    chk("t4_pkt_after", pkt_count_o, 0);
    chk("t4_count_after", count_o, 0);
    next_cycle();

    // Partial packet visibility (store-and-forward holds it, cut-through shows it).
    put(8'h01, 4'h0, 1'b0, 1'b0, acc);
    put(8'h02, 4'h0, 1'b0, 1'b0, acc);
    @(negedge clk_i);
    chk("t5_partial_valid", m_valid_o, !sf_mode);
    next_cycle();
    put(8'h03, 4'h0, 1'b0, 1'b1, acc);
    @(negedge clk_i);
    chk("t5_complete_valid", m_valid_o, 1);
    next_cycle();
    drain();

    // Oversize packet: full without a last beat must still present output.
    for (int i = 0; i < 10; i++) put(8'hC0 + 8'(i), 4'h1, 1'b0, 1'b0, acc);
    @(negedge clk_i);
    chk("t5_oversize_count", count_o, 8);
    chk("t5_oversize_valid", m_valid_o, 1);
    next_cycle();
    m_ready_i = 1'b1;
    next_cycle();
    m_ready_i = 1'b0;
    @(negedge clk_i);
    chk("t5_after_pop_valid", m_valid_o, !sf_mode);
    next_cycle();
    put(8'hEE, 4'hE, 1'b1, 1'b1, acc);
    chk("t5_last_acc", acc, 1);
    drain();

    // Reset mid-packet discards everything.
    for (int i = 0; i < 5; i++) put(8'h60 + 8'(i), 4'h6, 1'b0, 1'b0, acc);
    @(negedge clk_i);
    chk("t6_count_before", count_o, 5);
    next_cycle();
    do_reset();
    repeat (3) begin
      @(negedge clk_i);
      chk("t6_stay_empty", m_valid_o, 0);
    end
    chk("final_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/stream_packet_fifo.md
# stream_packet_fifo

Packet-aware FIFO placed directly downstream of the QoS stream arbiter, absorbing its merged output stream (data, qos, id, last) and decoupling it from the consumer's backpressure. Beats are stored in order with their sideband fields, and the block tracks how many complete packets it holds. An optional store-and-forward mode holds output until a whole packet is buffered, so the consumer never sees a packet stall mid-flight because of a slow arbiter source.

## Interface
- T_DATA_WIDTH, 8, data width per beat
- T_QOS__WIDTH, 4, QoS field width
- STREAM_COUNT, 2, number of arbitrated source streams
- T_ID___WIDTH, $clog2(STREAM_COUNT), stream id width
- FIFO_DEPTH, 8, beats of storage; power of two, >= 2
- CNT_WIDTH, $clog2(FIFO_DEPTH)+1, occupancy counter width

- clk_i  in  1  single clock, all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- s_data_i  in  T_DATA_WIDTH  input beat data
- s_qos_i  in  T_QOS__WIDTH  input beat QoS
- s_id_i  in  T_ID___WIDTH  input beat source id
- s_last_i  in  1  last beat of packet
- s_valid_i  in  1  input beat valid
- s_ready_o  out  1  FIFO can accept a beat
- m_data_o  out  T_DATA_WIDTH  head beat data
- m_qos_o  out  T_QOS__WIDTH  head beat QoS
- m_id_o  out  T_ID___WIDTH  head beat id
- m_last_o  out  1  head beat last flag
- m_valid_o  out  1  head beat valid
- m_ready_i  in  1  consumer accepts head beat
- count_o  out  CNT_WIDTH  beats currently stored
- pkt_count_o  out  CNT_WIDTH  complete packets (last beats) currently stored

## Operation
- Storage: register array of FIFO_DEPTH entries, each {data, qos, id, last}; write pointer wr_ptr, read pointer rd_ptr, log2(FIFO_DEPTH) bits, natural wrap from FIFO_DEPTH-1 to 0.
- Write: s_valid_i & s_ready_o at a rising edge stores the beat at wr_ptr, wr_ptr+1.
- Read: m_valid_o & m_ready_i at a rising edge pops the head, rd_ptr+1.
- count_o: +1 write-only, -1 read-only, unchanged on simultaneous write+read or neither.
- pkt_count_o: +1 on accepted beat with s_last_i=1, -1 on popped beat with m_last_o=1; both in one cycle leaves it unchanged.
- s_ready_o = ~rst_i & (count_o != FIFO_DEPTH); does not depend on m_ready_i (a full FIFO does not accept even when popping that cycle).
- m_data_o/m_qos_o/m_id_o/m_last_o: entry at rd_ptr (first-word fall-through); values stable while m_valid_o=1 and m_ready_i=0.
- m_valid_o (base mode) = (count_o != 0).
- Beat order and field values preserved exactly; no reordering by id or qos.

## Timing
- Reset (rst_i=1 at an edge): wr_ptr, rd_ptr, count_o, pkt_count_o, all entries <= 0; while rst_i=1, s_ready_o=0, m_valid_o=0, m_data_o/m_qos_o/m_id_o/m_last_o=0.
- Reset mid-packet discards all stored beats, complete or partial; no partial packet emerges after reset.
- Latency: beat accepted at edge N appears on m_* with m_valid_o=1 in cycle after edge N (1 cycle) in base mode.
- Full: count_o=FIFO_DEPTH -> s_ready_o=0 in the same cycle; deasserts to 1 in the cycle after the first pop.
- Empty: count_o=0 -> m_valid_o=0; m_ready_i ignored.
- Throughput: one write and one read per cycle sustained when neither full nor empty.

## Configuration
- Macro STREAM_PACKET_FIFO_STORE_FWD_EN.
- Undefined: m_valid_o = (count_o != 0) (cut-through).
- Defined: m_valid_o = (count_o != 0) & ((pkt_count_o != 0) | (count_o == FIFO_DEPTH)). A packet starts only after its last beat is stored; once its first beat pops, remaining beats of that packet stay valid as stored. Full-with-no-complete-packet falls back to cut-through to prevent deadlock on packets longer than FIFO_DEPTH.
- pkt_count_o present and counting in both builds.

## Test plan
- Reset then write 3 beats data 0x11,0x22,0x33 (last on 0x33), m_ready_i=1 -> m_valid_o 1 cycle after first write, output 0x11,0x22,0x33 in order, count_o returns to 0.
- m_ready_i=0, write 8 beats -> count_o=8, s_ready_o=0, 9th beat not accepted; one pop -> s_ready_o=1 next cycle.
- Simultaneous write+read every cycle for 20 beats at count_o=4 -> count_o stays 4, pointers wrap, data order intact.
- Fields qos=0xA, id=1, last=1 on beat 0x5C -> m_qos_o=0xA, m_id_o=1, m_last_o=1 with m_data_o=0x5C; pkt_count_o 1 -> 0 on pop.
- STORE_FWD_EN: write beats 0x01,0x02 without last -> m_valid_o=0; write 0x03 with last -> m_valid_o=1 next cycle; 10-beat packet without last fills 8 -> m_valid_o=1 (fallback).
- Assert rst_i with 5 beats stored mid-packet -> count_o=0, pkt_count_o=0, m_valid_o=0, s_ready_o=1 in the cycle after rst_i drops.
